// File: rtl/encoder_pipe_sv.sv
`default_nettype none
// ============================================================================
// encoder_pipe_sv : N-to-W encoder (strict / priority / round-robin modes)
//                   with one valid/ready output stage and saturating error count
// Rev 1.0
// ============================================================================
module encoder_pipe_sv #(
   parameter  int N          = 10,
   parameter  int HIGH_FIRST = 0,
   parameter  int CNT_W      = 16,
   localparam int W          = $clog2(N + 1)
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic [1:0]       iMODE,
   input  logic             iVALID,
   output logic             oREADY,
   input  logic [N-1:0]     iIN,
   output logic             oVALID,
   input  logic             iREADY,
   output logic [W-1:0]     oOUT,
   output logic             oHIT,
   output logic             oERR,
   output logic [CNT_W-1:0] oERRCNT
);

   localparam logic [W-1:0] NULL_CODE = '1;
   localparam logic [W-1:0] LAST_IDX  = W'(N - 1);

   logic             valid_q;
   logic [W-1:0]     out_q, out_d;
   logic             hit_q, hit_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q;
   logic [W-1:0]     ptr_q, ptr_d;

   logic             accept;
   logic             any_set, multi_set, rr_found;
   logic [W-1:0]     lo_idx, hi_idx, rr_idx;

   // One scan finds lowest, highest and first-at-or-above-pointer set bits.
   always_comb begin
      any_set   = 1'b0;
      multi_set = 1'b0;
      rr_found  = 1'b0;
      lo_idx    = NULL_CODE;
      hi_idx    = NULL_CODE;
      rr_idx    = NULL_CODE;
      for (int i = N - 1; i >= 0; i--) begin
         if (iIN[i]) begin
            lo_idx = W'(i);
            if (i >= int'(ptr_q)) begin
               rr_idx   = W'(i);
               rr_found = 1'b1;
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         if (iIN[i]) begin
            multi_set = multi_set | any_set;
            any_set   = 1'b1;
            hi_idx    = W'(i);
         end
      end
      // Nothing at or above the pointer: wrap to the lowest set bit.
      if (!rr_found) begin
         rr_idx = lo_idx;
      end
   end

   always_comb begin
      out_d = NULL_CODE;
      hit_d = any_set;
      err_d = 1'b0;
      ptr_d = ptr_q;
      case (iMODE)
         2'b00: begin
            err_d = !any_set || multi_set;
            if (any_set && !multi_set) begin
               out_d = lo_idx;
            end
         end
         2'b10: begin
            out_d = rr_idx;
            if (any_set) begin
               ptr_d = (rr_idx == LAST_IDX) ? '0 : rr_idx + 1'b1;
            end
         end
         default: begin
            out_d = (HIGH_FIRST != 0) ? hi_idx : lo_idx;
         end
      endcase
   end

   assign oREADY = !valid_q || iREADY;
   assign accept = iVALID && oREADY;

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         valid_q <= 1'b0;
         out_q   <= NULL_CODE;
         hit_q   <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         ptr_q   <= '0;
      end else if (accept) begin
         valid_q <= 1'b1;
         out_q   <= out_d;
         hit_q   <= hit_d;
         err_q   <= err_d;
         ptr_q   <= ptr_d;
         if (err_d && !(&cnt_q)) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end else if (iREADY) begin
         valid_q <= 1'b0;
      end
   end

   assign oVALID  = valid_q;
   assign oOUT    = out_q;
   assign oHIT    = hit_q;
   assign oERR    = err_q;
   assign oERRCNT = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_encoder_pipe_sv.sv
`default_nettype none
// ============================================================================
// tb_encoder_pipe_sv : directed + random check of encoder_pipe_sv against a
//                      behavioural model (two builds: low-first/16b, high-first/2b)
// Rev 1.0
// ============================================================================
module tb_encoder_pipe_sv;

   localparam int N    = 10;
   localparam int W    = 4;
   localparam int NULC = (1 << W) - 1;

   logic         iCLK = 1'b0;
   logic         iRST;
   logic [1:0]   iMODE;
   logic         iVALID;
   logic [N-1:0] iIN;
   logic         iREADY;

   logic         rdy_a, vld_a, hit_a, err_a;
   logic [W-1:0] out_a;
   logic [15:0]  cnt_a;
   logic         rdy_b, vld_b, hit_b, err_b;
   logic [W-1:0] out_b;
   logic [1:0]   cnt_b;

   int total = 0;
   int bad   = 0;

   // model state
   bit m_valid, m_hit, m_err;
   int m_out [2];
   int m_cnt [2];
   int m_ptr;
   int cmax  [2] = '{65535, 3};

   always #5 iCLK = ~iCLK;

   encoder_pipe_sv #(.N(N), .HIGH_FIRST(0), .CNT_W(16)) dut_a (
      .iCLK(iCLK), .iRST(iRST), .iMODE(iMODE), .iVALID(iVALID), .oREADY(rdy_a),
      .iIN(iIN), .oVALID(vld_a), .iREADY(iREADY), .oOUT(out_a), .oHIT(hit_a),
      .oERR(err_a), .oERRCNT(cnt_a)
   );

   encoder_pipe_sv #(.N(N), .HIGH_FIRST(1), .CNT_W(2)) dut_b (
      .iCLK(iCLK), .iRST(iRST), .iMODE(iMODE), .iVALID(iVALID), .oREADY(rdy_b),
      .iIN(iIN), .oVALID(vld_b), .iREADY(iREADY), .oOUT(out_b), .oHIT(hit_b),
      .oERR(err_b), .oERRCNT(cnt_b)
   );

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic ref_enc(input logic [1:0] mode, input logic [N-1:0] v, input int p,
                          input bit hf, output int code, output bit hit, output bit err);
      int ones;
      ones = $countones(v);
      hit  = (ones > 0);
      err  = 1'b0;
      code = NULC;
      case (mode)
         2'b00: begin
            err = (ones != 1);
            if (ones == 1)
               for (int i = 0; i < N; i++) if (v[i]) code = i;
         end
         2'b10: begin
            for (int j = 0; j < N; j++) begin
               int k;
               k = (p + j) % N;
               if (v[k]) begin
                  code = k;
                  break;
               end
            end
         end
         default: begin
            for (int j = 0; j < N; j++) begin
               int k;
               k = hf ? (N - 1 - j) : j;
               if (v[k]) begin
                  code = k;
                  break;
               end
            end
         end
      endcase
   endtask

   task automatic step(input bit rst, input logic [1:0] mode, input bit v,
                       input logic [N-1:0] in, input bit rdy);
      bit exp_rdy, acc;
      iRST = rst; iMODE = mode; iVALID = v; iIN = in; iREADY = rdy;
      #1;
      exp_rdy = !m_valid || rdy;
      if (!rst) begin
         chk_eq("ready_a", rdy_a, exp_rdy);
         chk_eq("ready_b", rdy_b, exp_rdy);
      end
      acc = v && exp_rdy;
      @(posedge iCLK);
      if (rst) begin
         m_valid = 0; m_hit = 0; m_err = 0; m_ptr = 0;
         for (int d = 0; d < 2; d++) begin
            m_out[d] = NULC;
            m_cnt[d] = 0;
         end
      end else if (acc) begin
         int code;
         bit h, e;
         for (int d = 0; d < 2; d++) begin
            ref_enc(mode, in, m_ptr, (d == 1), code, h, e);
            m_out[d] = code;
            if (e && m_cnt[d] < cmax[d]) m_cnt[d]++;
         end
         m_hit   = h;
         m_err   = e;
         m_valid = 1;
         if (mode == 2'b10 && h) m_ptr = (m_out[0] == N - 1) ? 0 : m_out[0] + 1;
      end else if (m_valid && rdy) begin
         m_valid = 0;
      end
      #1;
      chk_eq("valid_a", vld_a, m_valid);
      chk_eq("valid_b", vld_b, m_valid);
      chk_eq("out_a",   out_a, m_out[0]);
      chk_eq("out_b",   out_b, m_out[1]);
      chk_eq("hit_a",   hit_a, m_hit);
      chk_eq("hit_b",   hit_b, m_hit);
      chk_eq("err_a",   err_a, m_err);
      chk_eq("err_b",   err_b, m_err);
      chk_eq("cnt_a",   cnt_a, m_cnt[0]);
      chk_eq("cnt_b",   cnt_b, m_cnt[1]);
   endtask

   initial begin
      logic [N-1:0] rin;
      m_valid = 0; m_ptr = 0;

      step(1, 2'b00, 0, '0, 1);
      step(1, 2'b00, 0, '0, 1);

      // strict one-hot, back-to-back
      step(0, 2'b00, 1, 10'h001, 1);
      step(0, 2'b00, 1, 10'h200, 1);
      step(0, 2'b00, 1, 10'h010, 1);
      step(0, 2'b00, 0, 10'h000, 1);

      // strict violations, then drive the 2-bit counter into saturation
      step(0, 2'b00, 1, 10'h000, 1);
      step(0, 2'b00, 1, 10'h0C0, 1);
      chk_eq("plan_cnt2", cnt_a, 2);
      for (int i = 0; i < 3; i++) step(0, 2'b00, 1, 10'h000, 1);
      chk_eq("plan_sat", cnt_b, 3);

      // fixed priority
      step(0, 2'b01, 1, 10'h0C4, 1);
      chk_eq("plan_lo", out_a, 2);
      chk_eq("plan_hi", out_b, 7);
      step(0, 2'b01, 1, 10'h000, 1);
      step(0, 2'b11, 1, 10'h0C4, 1);

      // round robin
      for (int i = 0; i < 4; i++) step(0, 2'b10, 1, 10'h221, 1);
      step(0, 2'b10, 1, 10'h000, 1);
      step(0, 2'b10, 1, 10'h221, 1);
      chk_eq("plan_rr", out_a, 5);
      step(0, 2'b10, 0, 10'h000, 1);

      // backpressure
      step(0, 2'b00, 1, 10'h001, 1);
      for (int i = 0; i < 3; i++) step(0, 2'b00, 1, 10'h002, 0);
      step(0, 2'b00, 1, 10'h002, 1);
      chk_eq("plan_bp", out_a, 1);
      step(0, 2'b00, 0, 10'h000, 1);

      // reset while holding a result with pointer at 6
      step(1, 2'b00, 0, '0, 1);
      step(0, 2'b10, 1, 10'h020, 0);
      step(1, 2'b10, 1, 10'h020, 0);
      step(0, 2'b10, 1, 10'h221, 1);
      chk_eq("plan_rst_rr", out_a, 0);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 3))
            0:       rin = '0;
            1:       rin = N'(1) << $urandom_range(0, N - 1);
            default: rin = N'($urandom);
         endcase
         step(($urandom_range(0, 49) == 0), 2'($urandom), ($urandom_range(0, 3) != 0),
              rin, ($urandom_range(0, 9) < 7));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
